// File: rtl/sprite_line_select.sv
// sprite_line_select: per-pixel frontmost-object resolver with a per-scanline slot prefetch (optional SPRITE_FLIP_EN).
// Latency: 2 vga_clk cycles from row_addr/col_addr to outputs; the line pre-scan takes OBJ_NUM+2 cycles after a row change.
// Backpressure: none; table writes are always accepted and the pixel path is free-running.
module sprite_line_select #(
    parameter int         OBJ_NUM    = 32,
    parameter int         LINE_SLOTS = 8,
    parameter logic [5:0] BG_TYPE    = 6'd0,
    parameter int         BG_TILE    = 16
) (
    input  logic                       vga_clk,
    input  logic                       clrn,
    input  logic [8:0]                 row_addr,
    input  logic [9:0]                 col_addr,
    input  logic                       obj_we,
    input  logic [$clog2(OBJ_NUM)-1:0] obj_idx,
    input  logic                       obj_valid,
    input  logic [5:0]                 obj_type,
    input  logic [10:0]                obj_x,
    input  logic [10:0]                obj_y,
    input  logic [10:0]                obj_hgt,
    input  logic [10:0]                obj_wid,
    input  logic                       obj_flip,
    // "type" is a reserved word, so the sprite select output is named sprite_type
    output logic [5:0]                 sprite_type,
    output logic [10:0]                h,
    output logic [10:0]                w,
    output logic [11:0]                mask,
    output logic                       line_full
);

    localparam int IDXW = $clog2(OBJ_NUM);
    localparam int SLW  = $clog2(LINE_SLOTS);
    localparam int SCW  = SLW + 1;

    typedef struct packed {
        logic [5:0]  typ;
        logic [10:0] x;
        logic [10:0] y;
        logic [10:0] hgt;
        logic [10:0] wid;
`ifdef SPRITE_FLIP_EN
        logic        flip;
`endif
    } obj_t;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SCAN, S_DONE} state_t;

    // object table
    logic [OBJ_NUM-1:0]    r_tbl_vld;
    obj_t                  r_tbl [OBJ_NUM];
    obj_t                  w_wr_obj;

    // ping-pong line buffers, indexed by buffer then slot
    logic [LINE_SLOTS-1:0] r_slot_vld [2];
    obj_t                  r_slot [2][LINE_SLOTS];

    // scan state
    state_t                r_state;
    logic                  r_act;
    logic                  w_shd;
    logic [8:0]            r_row_prev;
    logic [11:0]           r_target;
    logic [IDXW-1:0]       r_scan_idx;
    logic [SCW-1:0]        r_slot_cnt;
    logic                  r_shadow_ovf;
    logic                  w_trigger;
    obj_t                  w_scan_obj;
    logic                  w_scan_hit;

    // pixel path
    logic [8:0]            r_row;
    logic [9:0]            r_col;
    logic                  w_hit;
    obj_t                  w_hit_obj;
    logic                  w_blank;
    logic [10:0]           w_row_off;
    logic [10:0]           w_col_off;
    logic [10:0]           w_w_hit;

`ifndef SPRITE_FLIP_EN
    logic                  w_unused_flip;
    assign w_unused_flip = obj_flip;
`endif

    // pack write-port fields into a table entry
    always_comb begin
        w_wr_obj      = '0;
        w_wr_obj.typ  = obj_type;
        w_wr_obj.x    = obj_x;
        w_wr_obj.y    = obj_y;
        w_wr_obj.hgt  = obj_hgt;
        w_wr_obj.wid  = obj_wid;
`ifdef SPRITE_FLIP_EN
        w_wr_obj.flip = obj_flip;
`endif
    end

    // object table writes from game logic
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r_tbl_vld <= '0;
            for (int i = 0; i < OBJ_NUM; i++) r_tbl[i] <= '0;
        end else if (obj_we) begin
            r_tbl_vld[obj_idx] <= obj_valid;
            r_tbl[obj_idx]     <= w_wr_obj;
        end
    end

    assign w_shd      = ~r_act;
    assign w_trigger  = (row_addr != r_row_prev);
    assign w_scan_obj = r_tbl[r_scan_idx];
    // 12-bit compare so y+hgt cannot wrap
    assign w_scan_hit = r_tbl_vld[r_scan_idx] &&
                        ({1'b0, w_scan_obj.y} <= r_target) &&
                        (r_target < ({1'b0, w_scan_obj.y} + {1'b0, w_scan_obj.hgt}));

    // line pre-scan FSM: swap buffers on a new row, then fill the shadow for the next row
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r_state      <= S_IDLE;
            r_act        <= 1'b0;
            r_row_prev   <= '0;
            r_target     <= '0;
            r_scan_idx   <= '0;
            r_slot_cnt   <= '0;
            r_shadow_ovf <= 1'b0;
            line_full    <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                r_slot_vld[b] <= '0;
                for (int s = 0; s < LINE_SLOTS; s++) r_slot[b][s] <= '0;
            end
        end else if (w_trigger) begin
            r_row_prev <= row_addr;
            r_act      <= ~r_act;
            line_full  <= r_shadow_ovf;
            r_target   <= (row_addr == 9'd479) ? 12'd0 : ({3'b000, row_addr} + 12'd1);
            r_state    <= S_CLEAR;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_slot_vld[w_shd] <= '0;
                    r_slot_cnt        <= '0;
                    r_shadow_ovf      <= 1'b0;
                    r_scan_idx        <= '0;
                    r_state           <= S_SCAN;
                end
                S_SCAN: begin
                    if (w_scan_hit) begin
                        if (r_slot_cnt < SCW'(LINE_SLOTS)) begin
                            r_slot[w_shd][r_slot_cnt[SLW-1:0]]     <= w_scan_obj;
                            r_slot_vld[w_shd][r_slot_cnt[SLW-1:0]] <= 1'b1;
                            r_slot_cnt                             <= r_slot_cnt + 1'b1;
                        end else begin
                            r_shadow_ovf <= 1'b1;
                        end
                    end
                    if (r_scan_idx == IDXW'(OBJ_NUM - 1)) r_state <= S_DONE;
                    r_scan_idx <= r_scan_idx + 1'b1;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // stage 1: register the pixel coordinate
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r_row <= '0;
            r_col <= '0;
        end else begin
            r_row <= row_addr;
            r_col <= col_addr;
        end
    end

    // frontmost active slot covering the column (lowest slot index wins)
    always_comb begin
        w_hit     = 1'b0;
        w_hit_obj = '0;
        for (int j = LINE_SLOTS - 1; j >= 0; j--) begin
            if (r_slot_vld[r_act][j] &&
                ({1'b0, r_slot[r_act][j].x} <= {2'b00, r_col}) &&
                ({2'b00, r_col} < ({1'b0, r_slot[r_act][j].x} + {1'b0, r_slot[r_act][j].wid}))) begin
                w_hit     = 1'b1;
                w_hit_obj = r_slot[r_act][j];
            end
        end
    end

    assign w_blank   = (r_col >= 10'd640) || (r_row >= 9'd480);
    assign w_row_off = {2'b00, r_row} - w_hit_obj.y;
    assign w_col_off = {1'b0, r_col} - w_hit_obj.x;
`ifdef SPRITE_FLIP_EN
    assign w_w_hit   = w_hit_obj.flip ? (w_hit_obj.wid - 11'd1 - w_col_off) : w_col_off;
`else
    assign w_w_hit   = w_col_off;
`endif

    // stage 2: registered sprite select, offsets and mask
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            sprite_type <= BG_TYPE;
            h           <= '0;
            w           <= '0;
            mask        <= '0;
        end else if (w_hit && !w_blank) begin
            sprite_type <= w_hit_obj.typ;
            h           <= w_row_off;
            w           <= w_w_hit;
            mask        <= 12'hFFF;
        end else begin
            sprite_type <= BG_TYPE;
            h           <= {2'b00, r_row} & 11'(BG_TILE - 1);
            w           <= {1'b0, r_col} & 11'(BG_TILE - 1);
            mask        <= w_blank ? 12'h000 : 12'hFFF;
        end
    end

endmodule

// File: tb/tb_sprite_line_select.sv
// Self-checking bench for sprite_line_select: directed vector table, corner sequences, random rows vs. a reference model.
// Latency: outputs sampled 2 clocks after each coordinate is applied, #1 past the edge.
// Backpressure: not applicable; all waits are fixed cycle counts.
module tb_sprite_line_select;

    logic        vga_clk = 1'b0;
    logic        clrn;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;
    logic        obj_we;
    logic [4:0]  obj_idx;
    logic        obj_valid;
    logic [5:0]  obj_type;
    logic [10:0] obj_x, obj_y, obj_hgt, obj_wid;
    logic        obj_flip;
    logic [5:0]  sprite_type;
    logic [10:0] h, w;
    logic [11:0] mask;
    logic        line_full;

    int n_chk  = 0;
    int n_pass = 0;

    // reference object table
    int m_vld [32];
    int m_t   [32];
    int m_x   [32];
    int m_y   [32];
    int m_h   [32];
    int m_w   [32];
    int m_f   [32];

    typedef struct {
        int row;
        int col;
        int typ;
        int hh;
        int ww;
        int mk;
    } vec_t;

    vec_t vecs [11];

    sprite_line_select dut (
        .vga_clk     (vga_clk),
        .clrn        (clrn),
        .row_addr    (row_addr),
        .col_addr    (col_addr),
        .obj_we      (obj_we),
        .obj_idx     (obj_idx),
        .obj_valid   (obj_valid),
        .obj_type    (obj_type),
        .obj_x       (obj_x),
        .obj_y       (obj_y),
        .obj_hgt     (obj_hgt),
        .obj_wid     (obj_wid),
        .obj_flip    (obj_flip),
        .sprite_type (sprite_type),
        .h           (h),
        .w           (w),
        .mask        (mask),
        .line_full   (line_full)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge vga_clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // pixel expected from the rules: first 8 row-covering objects in index order, then frontmost by column
    function automatic void model_pix(input int row, input int col,
                                      output int t, output int hh, output int ww, output int mk);
        int  hits;
        bit  found;
        bit  blank;
        blank = (col >= 640) || (row >= 480);
        t = 0; hh = row % 16; ww = col % 16; mk = blank ? 0 : 'hFFF;
        hits = 0; found = 0;
        for (int i = 0; i < 32; i++) begin
            if (m_vld[i] != 0 && m_y[i] <= row && row < m_y[i] + m_h[i]) begin
                hits++;
                if (!blank && !found && hits <= 8 && m_x[i] <= col && col < m_x[i] + m_w[i]) begin
                    found = 1;
                    t  = m_t[i];
                    hh = row - m_y[i];
                    ww = col - m_x[i];
`ifdef SPRITE_FLIP_EN
                    if (m_f[i] != 0) ww = m_w[i] - 1 - (col - m_x[i]);
`endif
                end
            end
        end
    endfunction

    function automatic int model_full(input int row);
        int hits;
        hits = 0;
        for (int i = 0; i < 32; i++)
            if (m_vld[i] != 0 && m_y[i] <= row && row < m_y[i] + m_h[i]) hits++;
        return (hits > 8) ? 1 : 0;
    endfunction

    task automatic wr(input int idx, input int vld, input int typ, input int x, input int y,
                      input int hg, input int wd, input int fl);
        obj_we    = 1'b1;
        obj_idx   = 5'(idx);
        obj_valid = 1'(vld);
        obj_type  = 6'(typ);
        obj_x     = 11'(x);
        obj_y     = 11'(y);
        obj_hgt   = 11'(hg);
        obj_wid   = 11'(wd);
        obj_flip  = 1'(fl);
        tick(1);
        obj_we    = 1'b0;
        m_vld[idx] = vld; m_t[idx] = typ; m_x[idx] = x; m_y[idx] = y;
        m_h[idx] = hg; m_w[idx] = wd; m_f[idx] = fl;
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        tick(3);
        clrn = 1'b1;
        for (int i = 0; i < 32; i++) m_vld[i] = 0;
        tick(1);
    endtask

    // visit the previous row (prefetch) and then the row itself
    task automatic show_row(input int r);
        col_addr = 10'd700;
        row_addr = 9'((r == 0) ? 479 : r - 1);
        tick(40);
        row_addr = 9'(r);
        tick(40);
    endtask

    task automatic probe(input string nm, input int col, input int et, input int eh,
                         input int ew, input int em);
        col_addr = 10'(col);
        tick(2);
        chk({nm, ".type"}, int'(sprite_type), et);
        chk({nm, ".h"},    int'(h),           eh);
        chk({nm, ".w"},    int'(w),           ew);
        chk({nm, ".mask"}, int'(mask),        em);
    endtask

    task automatic probe_model(input string nm, input int row, input int col);
        int t, hh, ww, mk;
        model_pix(row, col, t, hh, ww, mk);
        probe(nm, col, t, hh, ww, mk);
    endtask

    initial begin
        int cur;
        int r;
        clrn = 1'b0; row_addr = '0; col_addr = '0; obj_we = 1'b0; obj_idx = '0;
        obj_valid = 1'b0; obj_type = '0; obj_x = '0; obj_y = '0; obj_hgt = '0;
        obj_wid = '0; obj_flip = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_vld[i] = 0; m_t[i] = 0; m_x[i] = 0; m_y[i] = 0; m_h[i] = 0; m_w[i] = 0; m_f[i] = 0;
        end

        // reset state held across several edges
        tick(5);
        chk("rst.type", int'(sprite_type), 0);
        chk("rst.h",    int'(h),           0);
        chk("rst.w",    int'(w),           0);
        chk("rst.mask", int'(mask),        0);
        chk("rst.full", int'(line_full),   0);
        clrn = 1'b1;
        tick(1);

        // row 0 straight after reset is background: nothing was prefetched
        wr(0, 1, 3, 0, 0, 16, 16, 0);
        tick(4);
        probe("post_rst_bg", 5, 0, 0, 5, 'hFFF);

        // 479 -> 0 wrap prefetches an object at y=0
        show_row(0);
        probe("wrap", 5, 3, 0, 5, 'hFFF);

        // directed table: single object, overlap priority, blanking
        wr(0, 1, 5, 100, 50, 16, 16, 0);
        wr(3, 1, 9, 190, 55, 20, 20, 0);
        wr(1, 1, 7, 195, 58, 10, 10, 0);
        vecs[0]  = '{50,  100, 5, 0,  0,  'hFFF};
        vecs[1]  = '{50,  107, 5, 0,  7,  'hFFF};
        vecs[2]  = '{50,  115, 5, 0,  15, 'hFFF};
        vecs[3]  = '{50,  116, 0, 2,  4,  'hFFF};
        vecs[4]  = '{50,  99,  0, 2,  3,  'hFFF};
        vecs[5]  = '{50,  700, 0, 2,  12, 'h000};
        vecs[6]  = '{60,  200, 7, 2,  5,  'hFFF};
        vecs[7]  = '{60,  192, 9, 5,  2,  'hFFF};
        vecs[8]  = '{60,  205, 9, 5,  15, 'hFFF};
        vecs[9]  = '{60,  100, 5, 10, 0,  'hFFF};
        vecs[10] = '{500, 10,  0, 4,  10, 'h000};
        cur = -1;
        for (int k = 0; k < 11; k++) begin
            if (vecs[k].row != cur) begin
                show_row(vecs[k].row);
                cur = vecs[k].row;
            end
            probe($sformatf("vec%0d", k), vecs[k].col, vecs[k].typ, vecs[k].hh, vecs[k].ww, vecs[k].mk);
        end

`ifdef SPRITE_FLIP_EN
        // mirrored sprite
        wr(2, 1, 4, 300, 50, 16, 16, 1);
        show_row(50);
        probe("flip_l", 300, 4, 0, 15, 'hFFF);
        probe("flip_r", 315, 4, 0, 0,  'hFFF);
`endif

        // reset during a scan leaves both buffers empty
        col_addr = 10'd700;
        row_addr = 9'd49;
        tick(40);
        row_addr = 9'd50;
        tick(5);
        do_reset();
        wr(0, 1, 5, 100, 50, 16, 16, 0);
        tick(40);
        probe("rst_mid_scan", 100, 0, 2, 4, 'hFFF);
        chk("rst_mid_scan.full", int'(line_full), 0);

        // overflow: nine objects on row 120, ninth is dropped
        do_reset();
        for (int i = 0; i < 9; i++) wr(i, 1, i + 1, 20 * i, 120, 4, 10, 0);
        show_row(120);
        chk("ovf.full", int'(line_full), 1);
        for (int i = 0; i < 9; i++) begin
            if (i < 8) probe($sformatf("ovf%0d", i), 20 * i + 3, i + 1, 0, 3, 'hFFF);
            else       probe($sformatf("ovf%0d", i), 20 * i + 3, 0, 8, 3, 'hFFF);
        end
        show_row(126);
        chk("ovf_next.full", int'(line_full), 0);

        // random tables and rows against the reference model
        do_reset();
        for (int i = 0; i < 32; i++)
            wr(i, ($urandom_range(0, 99) < 85) ? 1 : 0, $urandom_range(1, 63),
               $urandom_range(0, 620), $urandom_range(0, 250), $urandom_range(1, 40),
               $urandom_range(1, 60), $urandom_range(0, 1));
        for (int k = 0; k < 25; k++) begin
            r = $urandom_range(0, 300);
            show_row(r);
            chk($sformatf("rnd_row%0d.full", r), int'(line_full), model_full(r));
            for (int c = 0; c < 16; c++)
                probe_model($sformatf("rnd_r%0d", r), r, $urandom_range(0, 799));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
